commit_monitor: RTL and testbench

- Sits directly downstream of the core's commit-state outputs (commit strobe, commit PC, commit instruction, register x10/a0) in the simulation top.
- Tracks program progress: counts cycles and commits, detects the halt instruction, and decides pass/fail from a0.
- Runs a no-commit watchdog so hung programs end the test.
- Buffers committed (pc, inst) pairs in a small trace FIFO that the bench drains through a valid/ready port.

---
 rtl/commit_monitor.sv | 186 ++++++++++++++++++
 tb/tb_commit_monitor.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Commit-stream monitor: tracks run progress, decides halt pass/fail or watchdog timeout,
// and optionally buffers (pc, inst) pairs in a trace FIFO when COMMIT_MON_TRACE_EN is defined.
module commit_monitor #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] HALT_INST      = 32'h0000006b,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             commit,
  input  logic [31:0]      commit_pc,
  input  logic [31:0]      commit_inst,
  input  logic [31:0]      a0,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_inst,
  output logic             trace_overflow
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2,
    TOUT = 2'd3
  } state_t;

  state_t           state_r;
  logic [WD_W-1:0]  wdogCnt_r;
  logic [CNT_W-1:0] commitCnt_r;
  logic [CNT_W-1:0] cycleCnt_r;
  logic             done_r;
  logic             pass_r;
  logic             timeout_r;
  logic             isHalt_s;

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      satInc = v;
    end else begin
      satInc = v + CNT_W'(1);
    end
  endfunction

  assign isHalt_s = (commit_inst == HALT_INST);

  // Run-state FSM with progress counters, watchdog and sticky verdict flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      wdogCnt_r   <= {WD_W{1'b0}};
      commitCnt_r <= {CNT_W{1'b0}};
      cycleCnt_r  <= {CNT_W{1'b0}};
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          cycleCnt_r <= satInc(cycleCnt_r);
          // A commit always beats the watchdog, even on the limiting cycle.
          if (commit) begin
            commitCnt_r <= satInc(commitCnt_r);
            wdogCnt_r   <= {WD_W{1'b0}};
            if (isHalt_s) begin
              state_r <= HALT;
              done_r  <= 1'b1;
              pass_r  <= (a0 == 32'h0000_0000);
            end else begin
              state_r <= RUN;
            end
          end else if (wdogCnt_r == WD_LIMIT) begin
            state_r   <= TOUT;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
            pass_r    <= 1'b0;
          end else begin
            wdogCnt_r <= wdogCnt_r + WD_W'(1);
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        TOUT: begin
          state_r <= TOUT;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done       = done_r;
  assign pass       = pass_r;
  assign timeout    = timeout_r;
  assign commit_cnt = commitCnt_r;
  assign cycle_cnt  = cycleCnt_r;

`ifdef COMMIT_MON_TRACE_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  logic [31:0]    pcMem_r   [FIFO_DEPTH];
  logic [31:0]    instMem_r [FIFO_DEPTH];
  logic [PTR_W:0] wrPtr_r;
  logic [PTR_W:0] rdPtr_r;
  logic           overflow_r;
  logic           countCommit_s;
  logic           empty_s;
  logic           full_s;
  logic           pop_s;
  logic           pushOk_s;

  assign countCommit_s = (state_r == RUN) && commit;
  assign empty_s       = (wrPtr_r == rdPtr_r);
  assign full_s        = (wrPtr_r[PTR_W] != rdPtr_r[PTR_W]) &&
                         (wrPtr_r[PTR_W-1:0] == rdPtr_r[PTR_W-1:0]);
  assign pop_s         = !empty_s && trace_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign pushOk_s      = countCommit_s && (!full_s || pop_s);

  // FIFO pointers and sticky drop flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr_r    <= {(PTR_W+1){1'b0}};
      rdPtr_r    <= {(PTR_W+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (pushOk_s) begin
        wrPtr_r <= wrPtr_r + (PTR_W+1)'(1);
      end else begin
        wrPtr_r <= wrPtr_r;
      end
      if (pop_s) begin
        rdPtr_r <= rdPtr_r + (PTR_W+1)'(1);
      end else begin
        rdPtr_r <= rdPtr_r;
      end
      if (countCommit_s && full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Entry storage; contents are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (pushOk_s) begin
      pcMem_r[wrPtr_r[PTR_W-1:0]]   <= commit_pc;
      instMem_r[wrPtr_r[PTR_W-1:0]] <= commit_inst;
    end
  end

  assign trace_valid    = !empty_s;
  assign trace_pc       = trace_valid ? pcMem_r[rdPtr_r[PTR_W-1:0]]   : 32'h0000_0000;
  assign trace_inst     = trace_valid ? instMem_r[rdPtr_r[PTR_W-1:0]] : 32'h0000_0000;
  assign trace_overflow = overflow_r;
`else
  logic unusedTrace_s;

  assign unusedTrace_s  = ^{trace_ready, commit_pc, 32'(FIFO_DEPTH)};
  assign trace_valid    = 1'b0;
  assign trace_pc       = 32'h0000_0000;
  assign trace_inst     = 32'h0000_0000;
  assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Self-checking bench for commit_monitor: vector table, directed corner sequences and
// randomized runs compared against a queue-based reference model.
module tb_commit_monitor;

  localparam int TMO   = 10;
  localparam int DEPTH = 8;
  localparam int SATW  = 4;
`ifdef COMMIT_MON_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic        clock, reset, start, commit, trace_ready;
  logic [31:0] commit_pc, commit_inst, a0;
  logic        done, pass, timeout, trace_valid, trace_overflow;
  logic [31:0] commit_cnt, cycle_cnt, trace_pc, trace_inst;
  logic        done2, pass2, timeout2, trace_valid2, trace_overflow2;
  logic [SATW-1:0] commit_cnt2, cycle_cnt2;
  logic [31:0] trace_pc2, trace_inst2;

  commit_monitor #(.TIMEOUT_CYCLES(TMO), .HALT_INST(32'h0000006b), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .start(start), .commit(commit), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .a0(a0), .done(done), .pass(pass), .timeout(timeout),
    .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_pc(trace_pc), .trace_inst(trace_inst),
    .trace_overflow(trace_overflow));

  // Narrow-counter instance fed the same stimulus, used for saturation checks.
  commit_monitor #(.TIMEOUT_CYCLES(TMO), .HALT_INST(32'h0000006b), .FIFO_DEPTH(DEPTH), .CNT_W(SATW)) dut2 (
    .clock(clock), .reset(reset), .start(start), .commit(commit), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .a0(a0), .done(done2), .pass(pass2), .timeout(timeout2),
    .commit_cnt(commit_cnt2), .cycle_cnt(cycle_cnt2), .trace_valid(trace_valid2),
    .trace_ready(trace_ready), .trace_pc(trace_pc2), .trace_inst(trace_inst2),
    .trace_overflow(trace_overflow2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nTests = 0;
  int nFail  = 0;

  // Reference model: program phase, counts as plain integers, trace as a queue.
  int          mPhase;  // 0 idle, 1 running, 2 halted, 3 timed out
  int          mIdle, mCc, mCyc;
  bit          mDone, mPass, mTo, mOvf;
  logic [63:0] mQ[$];

  typedef struct {
    logic st; logic cm; logic [31:0] pc; logic [31:0] inst; logic [31:0] a0; logic rdy;
    logic eDone; logic ePass; logic eTo; int eCc; int eCyc;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int satN(input int v);
    return (v > (1 << SATW) - 1) ? (1 << SATW) - 1 : v;
  endfunction

  task automatic modelReset();
    mPhase = 0; mIdle = 0; mCc = 0; mCyc = 0;
    mDone = 0; mPass = 0; mTo = 0; mOvf = 0;
    mQ.delete();
  endtask

  task automatic modelEdge();
    bit pop, push;
    pop  = TRACE && (mQ.size() > 0) && trace_ready;
    push = 1'b0;
    if (mPhase == 0) begin
      if (start) mPhase = 1;
    end else if (mPhase == 1) begin
      mCyc++;
      if (commit) begin
        mCc++;
        mIdle = 0;
        push  = 1'b1;
        if (commit_inst == 32'h0000006b) begin
          mPhase = 2; mDone = 1; mPass = (a0 == 32'd0);
        end
      end else begin
        mIdle++;
        if (mIdle >= TMO) begin
          mPhase = 3; mDone = 1; mTo = 1; mPass = 0;
        end
      end
    end
    if (pop) void'(mQ.pop_front());
    if (push && TRACE) begin
      if (mQ.size() < DEPTH) mQ.push_back({commit_pc, commit_inst});
      else mOvf = 1;
    end
  endtask

  task automatic checkModel();
    logic [63:0] head;
    head = (mQ.size() > 0) ? mQ[0] : 64'd0;
    chk("done", done, mDone);
    chk("pass", pass, mPass);
    chk("timeout", timeout, mTo);
    chk("commit_cnt", commit_cnt, mCc);
    chk("cycle_cnt", cycle_cnt, mCyc);
    chk("commit_cnt_sat", commit_cnt2, satN(mCc));
    chk("cycle_cnt_sat", cycle_cnt2, satN(mCyc));
    chk("trace_valid", trace_valid, mQ.size() > 0);
    chk("trace_overflow", trace_overflow, mOvf);
    chk("trace_pc", trace_pc, head[63:32]);
    chk("trace_inst", trace_inst, head[31:0]);
  endtask

  task automatic step(input logic st, input logic cm, input logic [31:0] pc,
                      input logic [31:0] inst, input logic [31:0] av, input logic rdy);
    start = st; commit = cm; commit_pc = pc; commit_inst = inst; a0 = av; trace_ready = rdy;
    @(posedge clock);
    modelEdge();
    #1;
    checkModel();
  endtask

  task automatic doReset();
    reset = 1'b1; start = 1'b0; commit = 1'b0; commit_pc = 32'd0;
    commit_inst = 32'd0; a0 = 32'd0; trace_ready = 1'b0;
    #3;
    modelReset();
    checkModel();
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Asynchronous reset between clock edges; outputs must clear before the next edge.
  task automatic midReset();
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkModel();
    chk("async_rst_cnt", commit_cnt, 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic vec_t mk(input logic st, input logic cm, input logic [31:0] pc,
                              input logic [31:0] inst, input logic [31:0] av,
                              input logic d, input logic p, input int cc, input int cy);
    vec_t v;
    v.st = st; v.cm = cm; v.pc = pc; v.inst = inst; v.a0 = av; v.rdy = 1'b0;
    v.eDone = d; v.ePass = p; v.eTo = 1'b0; v.eCc = cc; v.eCyc = cy;
    return v;
  endfunction

  task automatic runTable();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].st, tbl[i].cm, tbl[i].pc, tbl[i].inst, tbl[i].a0, tbl[i].rdy);
      chk("tbl_done", done, tbl[i].eDone);
      chk("tbl_pass", pass, tbl[i].ePass);
      chk("tbl_timeout", timeout, tbl[i].eTo);
      chk("tbl_commit_cnt", commit_cnt, tbl[i].eCc);
      chk("tbl_cycle_cnt", cycle_cnt, tbl[i].eCyc);
    end
  endtask

  task automatic drainFive();
    for (int i = 0; i < 5; i++) begin
      chk("drain_valid", trace_valid, TRACE);
      chk("drain_pc", trace_pc, TRACE ? 32'(4 * i) : 32'd0);
      step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    end
    chk("drain_empty", trace_valid, 1'b0);
  endtask

  initial begin
    int prob, stDelay;
    logic [31:0] expPc;
    reset = 1'b1;

    // Halt with a0==0 after ignored pre-start commits, then a halt after done.
    tbl[0] = mk(1'b0, 1'b1, 32'h40, 32'h13, 32'd0, 1'b0, 1'b0, 0, 0);
    tbl[1] = mk(1'b0, 1'b1, 32'h44, 32'h6b, 32'd0, 1'b0, 1'b0, 0, 0);
    tbl[2] = mk(1'b1, 1'b1, 32'h48, 32'h13, 32'd0, 1'b0, 1'b0, 0, 0);
    tbl[3] = mk(1'b1, 1'b1, 32'h00, 32'h13, 32'd5, 1'b0, 1'b0, 1, 1);
    tbl[4] = mk(1'b1, 1'b1, 32'h04, 32'h13, 32'd0, 1'b0, 1'b0, 2, 2);
    tbl[5] = mk(1'b1, 1'b1, 32'h08, 32'h13, 32'd0, 1'b0, 1'b0, 3, 3);
    tbl[6] = mk(1'b1, 1'b1, 32'h0c, 32'h13, 32'd0, 1'b0, 1'b0, 4, 4);
    tbl[7] = mk(1'b1, 1'b1, 32'h10, 32'h6b, 32'd0, 1'b1, 1'b1, 5, 5);
    tbl[8] = mk(1'b1, 1'b1, 32'h14, 32'h6b, 32'd1, 1'b1, 1'b1, 5, 5);
    tbl[9] = mk(1'b1, 1'b0, 32'h18, 32'h13, 32'd0, 1'b1, 1'b1, 5, 5);
    doReset();
    runTable();
    drainFive();

    // Same program failing: a0 nonzero at the halt.
    tbl[7].a0 = 32'd1;
    for (int i = 7; i < 10; i++) tbl[i].ePass = 1'b0;
    doReset();
    runTable();

    // Watchdog fires on the tenth idle RUN cycle and freezes the cycle count.
    doReset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i <= TMO; i++) begin
      step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk("tout_flag", timeout, i == TMO);
    end
    chk("tout_done", done, 1'b1);
    chk("tout_cyc", cycle_cnt, 32'd10);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h300, 32'h6b, 32'd0, 1'b0);
    chk("tout_frozen_cyc", cycle_cnt, 32'd10);
    chk("tout_frozen_cc", commit_cnt, 32'd0);
    chk("tout_pass", pass, 1'b0);

    // Commit on the limiting cycle wins; watchdog restarts from there.
    doReset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 1; i < TMO; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 32'h13, 32'd0, 1'b0);
    chk("limit_commit_to", timeout, 1'b0);
    chk("limit_commit_cc", commit_cnt, 32'd1);
    for (int i = 1; i < TMO; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("limit_rearm_to", timeout, 1'b0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("limit_late_to", timeout, 1'b1);
    chk("limit_late_cyc", cycle_cnt, 32'd20);

    // Overflow: 10 commits into 8 slots, then push alongside a pop while full.
    doReset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'h13, 32'd0, 1'b0);
    chk("ovf_flag", trace_overflow, TRACE);
    chk("ovf_head", trace_pc, TRACE ? 32'h100 : 32'd0);
    step(1'b1, 1'b1, 32'h200, 32'h13, 32'd0, 1'b1);
    for (int j = 0; j < DEPTH; j++) begin
      expPc = (j < DEPTH - 1) ? 32'h104 + 32'(4 * j) : 32'h200;
      chk("ovf_drain_pc", trace_pc, TRACE ? expPc : 32'd0);
      step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
    end
    chk("ovf_drain_empty", trace_valid, 1'b0);

    // Saturation of the narrow counters.
    doReset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 32'(4 * i), 32'h13, 32'd0, 1'b1);
    chk("sat_cc", commit_cnt2, 4'hf);
    chk("sat_cyc", cycle_cnt2, 4'hf);
    chk("sat_wide_cc", commit_cnt, 32'd20);

    // Asynchronous reset mid-run with three entries queued.
    doReset();
    step(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'h400 + 32'(4 * i), 32'h13, 32'd0, 1'b0);
    chk("pre_rst_cc", commit_cnt, 32'd3);
    midReset();
    step(1'b0, 1'b1, 32'h500, 32'h13, 32'd0, 1'b0);
    chk("post_rst_idle_cc", commit_cnt, 32'd0);
    chk("post_rst_idle_valid", trace_valid, 1'b0);

    // Randomized runs against the model.
    for (int run = 0; run < 30; run++) begin
      doReset();
      case (run % 3)
        0: prob = 5;
        1: prob = 40;
        default: prob = 90;
      endcase
      stDelay = $urandom_range(0, 4);
      for (int c = 0; c < 80; c++) begin
        step(c >= stDelay, $urandom_range(0, 99) < prob, $urandom,
             ($urandom_range(0, 29) == 0) ? 32'h6b : $urandom,
             32'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 299) == 0) midReset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
